// File: rtl/fw_msg_sequencer.sv
// Wishbone master that writes one firmware-test message (string, terminator,
// value registers, control trigger) into the fw interface slave.
module fw_msg_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RETRY_MAX = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_i,
  input  logic [1:0]  req_kind_i,
  input  logic [31:0] req_value_i,
  input  logic [31:0] req_expected_i,
  input  logic [6:0]  req_len_i,
  output logic [5:0]  chr_idx_o,
  input  logic [7:0]  chr_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int unsigned LEN_W   = 7;
  localparam int unsigned RTY_W   = 4;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(64);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(RETRY_MAX);
  localparam logic [31:0] STR_OFS = 32'h0000_001C;
  localparam logic [31:0] EXP_OFS = 32'h0000_0014;

  typedef enum logic [2:0] {IDLE, STR, TERM, VAL, EXP, CTRL, DONE, ABORT} state_t;

  state_t            state, state_n;
  logic [1:0]        kind, kind_n;
  logic [31:0]       value, value_n;
  logic [31:0]       expected, expected_n;
  logic [LEN_W-1:0]  len, len_n;
  logic [LEN_W-1:0]  idx, idx_n;
  logic [RTY_W-1:0]  rty, rty_n;
  logic [31:0]       adr_n, dat_n;
  logic [3:0]        sel_n;
  logic              cyc_n, done_n, err_n, busy_n, issue;
  logic [5:0]        chr_idx_n;

  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;

  // Next-state, latched request and next bus access
  always_comb begin
    state_n    = state;
    kind_n     = kind;
    value_n    = value;
    expected_n = expected;
    len_n      = len;
    idx_n      = idx;
    rty_n      = rty;
    adr_n      = wb_adr_o;
    dat_n      = wb_dat_o;
    sel_n      = wb_sel_o;
    cyc_n      = wb_cyc_o;
    done_n     = 1'b0;
    err_n      = 1'b0;
    issue      = 1'b0;

    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        cyc_n   = 1'b0;
        if (req_i) begin
          kind_n     = req_kind_i;
          value_n    = req_value_i;
          expected_n = req_expected_i;
          len_n      = (req_len_i > LEN_MAX) ? LEN_MAX : req_len_i;
          idx_n      = '0;
          rty_n      = '0;
          state_n    = (len_n != '0) ? STR : TERM;
          issue      = 1'b1;
        end
      end
      ABORT: begin
        state_n = IDLE;
        cyc_n   = 1'b0;
      end
      default: begin
        // stb low here is the idle gap after a response: reissue/advance
        if (!wb_stb_o) begin
          issue = 1'b1;
        end else if (wb_err_i) begin
          cyc_n   = 1'b0;
          state_n = ABORT;
          err_n   = 1'b1;
        end else if (wb_rty_i) begin
          cyc_n = 1'b0;
          if (rty == RTY_MAX) begin
            state_n = ABORT;
            err_n   = 1'b1;
          end else begin
            rty_n = rty + RTY_W'(1);
          end
        end else if (wb_ack_i) begin
          cyc_n = 1'b0;
          rty_n = '0;
          case (state)
            STR: begin
              idx_n = idx + LEN_W'(1);
              if (idx_n == len) state_n = (len < LEN_MAX) ? TERM : VAL;
            end
            TERM: state_n = VAL;
            VAL:  state_n = (kind == 2'd3) ? EXP : CTRL;
            EXP:  state_n = CTRL;
            CTRL: begin
              state_n = DONE;
              done_n  = 1'b1;
            end
            default: state_n = state;
          endcase
        end
      end
    endcase

    if (issue) begin
      cyc_n = 1'b1;
      case (state_n)
        STR: begin
          adr_n = BASE_ADDR + STR_OFS + 32'(idx_n);
          dat_n = {24'h0, chr_dat_i};
          sel_n = 4'h1;
        end
        TERM: begin
          adr_n = BASE_ADDR + STR_OFS + 32'(len_n);
          dat_n = 32'h0;
          sel_n = 4'h1;
        end
        VAL: begin
          adr_n = BASE_ADDR + 32'({kind_n, 2'b00}) + 32'h4;
          dat_n = value_n;
          sel_n = 4'hF;
        end
        EXP: begin
          adr_n = BASE_ADDR + EXP_OFS;
          dat_n = expected_n;
          sel_n = 4'hF;
        end
        CTRL: begin
          adr_n = BASE_ADDR;
          dat_n = 32'h1 << kind_n;
          sel_n = 4'hF;
        end
        default: cyc_n = 1'b0;
      endcase
    end

    busy_n    = (state_n != IDLE);
    chr_idx_n = (state_n == STR) ? idx_n[5:0] : 6'd0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      kind      <= '0;
      value     <= '0;
      expected  <= '0;
      len       <= '0;
      idx       <= '0;
      rty       <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      chr_idx_o <= '0;
    end else begin
      state     <= state_n;
      kind      <= kind_n;
      value     <= value_n;
      expected  <= expected_n;
      len       <= len_n;
      idx       <= idx_n;
      rty       <= rty_n;
      wb_adr_o  <= adr_n;
      wb_dat_o  <= dat_n;
      wb_sel_o  <= sel_n;
      wb_we_o   <= cyc_n;
      wb_cyc_o  <= cyc_n;
      wb_stb_o  <= cyc_n;
      busy_o    <= busy_n;
      done_o    <= done_n;
      err_o     <= err_n;
      chr_idx_o <= chr_idx_n;
    end
  end

endmodule

// File: tb/tb_fw_msg_sequencer.sv
// Scoreboard bench for fw_msg_sequencer: a scripted registered-ack Wishbone
// slave, a monitor checking every presented access against a queue.
module tb_fw_msg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  req_kind;
  logic [31:0] req_value, req_expected;
  logic [6:0]  req_len;
  logic [5:0]  chr_idx;
  logic [7:0]  chr_dat;
  logic        busy_o, done_o, err_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        s_ack, s_err, s_rty;

  logic [7:0]  str_mem [64];

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } acc_t;

  acc_t exp_q[$];
  acc_t mon_e;
  int   checks = 0;
  int   errors = 0;

  int   rty_cfg = 0;
  int   err_at_cfg = -1;
  int   s_acked, s_rty_used;

  fw_msg_sequencer #(.BASE_ADDR(32'h0000_0000), .RETRY_MAX(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_i(req), .req_kind_i(req_kind), .req_value_i(req_value),
    .req_expected_i(req_expected), .req_len_i(req_len),
    .chr_idx_o(chr_idx), .chr_dat_i(chr_dat),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_rty_i(s_rty)
  );

  always #5 clk = ~clk;

  assign chr_dat = str_mem[chr_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic push(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    exp_q.push_back('{adr: adr, dat: dat, sel: sel});
  endtask

  // Registered-response slave: answers one cycle after seeing stb, holds the
  // response one extra cycle (stale), so the master must ignore it while stb is low
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack <= 1'b0; s_rty <= 1'b0; s_err <= 1'b0;
      s_acked <= 0; s_rty_used <= 0;
    end else begin
      if (req) begin
        s_acked <= 0;
        s_rty_used <= 0;
      end
      if (wb_cyc_o && wb_stb_o && !(s_ack || s_rty || s_err)) begin
        if (s_acked == err_at_cfg) s_err <= 1'b1;
        else if (s_rty_used < rty_cfg) begin
          s_rty <= 1'b1;
          s_rty_used <= s_rty_used + 1;
        end else begin
          s_ack <= 1'b1;
          s_acked <= s_acked + 1;
        end
      end else if (!(wb_cyc_o && wb_stb_o)) begin
        s_ack <= 1'b0; s_rty <= 1'b0; s_err <= 1'b0;
      end
    end
  end

  // Monitor: every new access (rising stb) is compared against the queue head
  logic stb_q = 1'b0;
  always @(negedge clk) begin
    if (wb_stb_o && !stb_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access adr %h dat %h", wb_adr_o, wb_dat_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("acc_adr", wb_adr_o, mon_e.adr);
        chk("acc_dat", wb_dat_o, mon_e.dat);
        chk("acc_sel", 32'(wb_sel_o), 32'(mon_e.sel));
        chk("acc_we_cyc", 32'({wb_we_o, wb_cyc_o}), 32'h3);
      end
    end
    stb_q = wb_stb_o;
  end

  task automatic issue_req(input logic [1:0] kind, input logic [31:0] val,
                           input logic [31:0] expv, input logic [6:0] len);
    @(negedge clk);
    req_kind = kind; req_value = val; req_expected = expv; req_len = len; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    // Scramble request fields while busy; the latched copy must be used
    req_kind = ~kind; req_value = ~val; req_expected = ~expv; req_len = 7'd2;
  endtask

  task automatic run(input string name, input logic [1:0] kind, input logic [31:0] val,
                     input logic [31:0] expv, input logic [6:0] len,
                     input int exp_lat, input bit exp_abort);
    int k;
    bit seen;
    issue_req(kind, val, expv, len);
    k = 0;
    seen = 1'b0;
    while (k < 400 && !seen) begin
      @(negedge clk);
      if (done_o || err_o) seen = 1'b1;
      else begin
        @(posedge clk);
        k++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no done/err want pulse", name);
    end else begin
      chk({name, "_lat"}, 32'(k), 32'(exp_lat));
      chk({name, "_done"}, 32'(done_o), 32'(!exp_abort));
      chk({name, "_err"}, 32'(err_o), 32'(exp_abort));
      chk({name, "_chr_idx"}, 32'(chr_idx), 32'h0);
    end
    @(posedge clk);
    #1;
    chk({name, "_busy_after"}, 32'(busy_o), 32'h0);
    chk({name, "_pulse_after"}, 32'({done_o, err_o}), 32'h0);
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_kind = '0; req_value = '0; req_expected = '0; req_len = '0;
    for (int i = 0; i < 64; i++) str_mem[i] = 8'(i + 32'h20);
    str_mem[0] = 8'h61; str_mem[1] = 8'h62; str_mem[2] = 8'h63;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_cyc_stb", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'h0);
    chk("rst_pulses", 32'({done_o, err_o}), 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_cti_bte", 32'({wb_cti_o, wb_bte_o}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Report "abc": 6 accesses, done at 3*6-1
    push(32'h1C, 32'h61, 4'h1); push(32'h1D, 32'h62, 4'h1); push(32'h1E, 32'h63, 4'h1);
    push(32'h1F, 32'h00, 4'h1); push(32'h04, 32'hDEAD_0001, 4'hF); push(32'h00, 32'h1, 4'hF);
    run("report3", 2'd0, 32'hDEAD_0001, 32'h0, 7'd3, 17, 1'b0);

    // Compare, empty string
    push(32'h1C, 32'h0, 4'h1); push(32'h10, 32'h1234, 4'hF);
    push(32'h14, 32'h1235, 4'hF); push(32'h00, 32'h8, 4'hF);
    run("compare0", 2'd3, 32'h1234, 32'h1235, 7'd0, 11, 1'b0);

    // Error with length clamped to 64: no terminator
    for (int i = 0; i < 64; i++) push(32'h1C + 32'(i), {24'h0, str_mem[i]}, 4'h1);
    push(32'h0C, 32'hCAFE_F00D, 4'hF); push(32'h00, 32'h4, 4'hF);
    run("error64", 2'd2, 32'hCAFE_F00D, 32'h0, 7'd100, 197, 1'b0);

    // Four retries on the first byte, then success
    rty_cfg = 4;
    for (int i = 0; i < 5; i++) push(32'h1C, 32'h61, 4'h1);
    push(32'h1D, 32'h0, 4'h1); push(32'h08, 32'h0000_0042, 4'hF); push(32'h00, 32'h2, 4'hF);
    run("rty4", 2'd1, 32'h0000_0042, 32'h0, 7'd1, 23, 1'b0);

    // Five retries exceed the limit: abort, no control write
    rty_cfg = 5;
    for (int i = 0; i < 5; i++) push(32'h1C, 32'h61, 4'h1);
    run("rty5", 2'd0, 32'h0000_0077, 32'h0, 7'd1, 14, 1'b1);
    rty_cfg = 0;

    // Bus error on the value write
    err_at_cfg = 1;
    push(32'h1C, 32'h0, 4'h1); push(32'h04, 32'h5555_AAAA, 4'hF);
    run("err_val", 2'd0, 32'h5555_AAAA, 32'h0, 7'd0, 5, 1'b1);
    err_at_cfg = -1;

    // Asynchronous reset in the middle of the string phase
    for (int i = 0; i < 5; i++) push(32'h1C + 32'(i), {24'h0, str_mem[i]}, 4'h1);
    issue_req(2'd2, 32'h1, 32'h0, 7'd5);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cyc_stb", 32'({wb_cyc_o, wb_stb_o}), 32'h0);
    chk("midrst_busy", 32'(busy_o), 32'h0);
    chk("midrst_pulses", 32'({done_o, err_o}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_idle_pulses", 32'({done_o, err_o, busy_o}), 32'h0);

    push(32'h1C, 32'h61, 4'h1); push(32'h1D, 32'h62, 4'h1); push(32'h1E, 32'h0, 4'h1);
    push(32'h08, 32'h0BAD_BEEF, 4'hF); push(32'h00, 32'h2, 4'hF);
    run("warn_after_rst", 2'd1, 32'h0BAD_BEEF, 32'h0, 7'd2, 14, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
